program_loader: RTL and testbench

Instruction-memory writer that fills the CPU's instruction ROM from a byte stream before execution. It receives a length-prefixed, checksummed program image over a valid/ready byte interface and packs each 7-byte group into one 49-bit instruction word. It writes words to consecutive instruction-memory addresses and holds the CPU core in reset until a complete, verified image is loaded. The program counter and ROM remain the read side of the same memory.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/program_loader_if.sv | 28 ++
 rtl/word_assembler.sv | 39 +++
 rtl/program_loader.sv | 151 +++++++++++++++
 tb/tb_program_loader.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and loader state encoding for the instruction-memory loader.
package cpu_pkg;

  localparam int unsigned INSTR_W        = 49;
  localparam int unsigned ADDR_W         = 8;
  localparam int unsigned BYTES_PER_WORD = (INSTR_W + 7) / 8;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_HI,
    LD_LEN_LO,
    LD_PAYLOAD,
    LD_CHECK,
    LD_DONE,
    LD_ERROR
  } ld_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, instruction-memory write port and CPU status out.
interface program_loader_if #(
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W,
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W
);

  logic               start;
  logic [7:0]         s_data;
  logic               s_valid;
  logic               s_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_hold;
  logic               done;
  logic               error;

  modport master (
    output start, s_data, s_valid,
    input  s_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );

  modport slave (
    input  start, s_data, s_valid,
    output s_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );

endinterface

// File: rtl/word_assembler.sv
// Packs big-endian bytes into one instruction word; strobes on the last byte of each word.
module word_assembler #(
  parameter int unsigned BYTES  = 7,
  parameter int unsigned WORD_W = 49
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [7:0]        i_data,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_done
);

  localparam int unsigned CntW = $clog2(BYTES);

  // Only the bits that survive into the word are kept; the leading pad bits fall off the top.
  logic [WORD_W-9:0] r_shift;
  logic [CntW-1:0]   r_cnt;
  logic              w_last;

  assign w_last      = (r_cnt == CntW'(BYTES - 1));
  assign o_word      = {r_shift, i_data};
  assign o_word_done = i_valid && w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_valid) begin
      r_shift <= o_word[WORD_W-9:0];
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction memory and
// keeps the CPU in reset until the whole image has been written and verified.
module program_loader #(
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W,
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  program_loader_if.slave  io_ld
);

  import cpu_pkg::*;

  localparam int unsigned BytesPerWord = (INSTR_W + 7) / 8;
  localparam int unsigned CntW         = ADDR_W + 1;

  ld_state_e          r_state;
  logic [7:0]         r_len_hi;
  logic [7:0]         r_xor;
  logic [CntW-1:0]    r_len;
  logic [CntW-1:0]    r_word_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_wdata;
  logic               r_ready;
  logic               r_we;
  logic               r_hold;
  logic               r_done;
  logic               r_error;

  logic               w_xfer;
  logic               w_start;
  logic               w_pay_xfer;
  logic [15:0]        w_len;
  logic               w_oversize;
  logic [CntW-1:0]    w_word_cnt_inc;
  logic               w_word_done;
  logic [INSTR_W-1:0] w_word;

  assign w_xfer         = io_ld.s_valid && r_ready;
  assign w_start        = io_ld.start &&
                          (r_state == LD_IDLE || r_state == LD_DONE || r_state == LD_ERROR);
  assign w_pay_xfer     = w_xfer && (r_state == LD_PAYLOAD);
  assign w_len          = {r_len_hi, io_ld.s_data};
  // Exactly 2^ADDR_W words still fits; only strictly larger counts are rejected.
  assign w_oversize     = 32'(w_len) > (32'd1 << ADDR_W);
  assign w_word_cnt_inc = r_word_cnt + 1'b1;

  word_assembler #(
    .BYTES  (BytesPerWord),
    .WORD_W (INSTR_W)
  ) u_word_assembler (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (w_start),
    .i_valid     (w_pay_xfer),
    .i_data      (io_ld.s_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= LD_IDLE;
      r_len_hi   <= '0;
      r_xor      <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ready    <= 1'b0;
      r_we       <= 1'b0;
      r_hold     <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_we) begin
        r_addr <= r_addr + 1'b1;
      end
      if (w_start) begin
        r_state    <= LD_LEN_HI;
        r_ready    <= 1'b1;
        r_hold     <= 1'b1;
        r_done     <= 1'b0;
        r_error    <= 1'b0;
        r_xor      <= '0;
        r_word_cnt <= '0;
        r_addr     <= '0;
      end else begin
        case (r_state)
          LD_LEN_HI: begin
            if (w_xfer) begin
              r_len_hi <= io_ld.s_data;
              r_state  <= LD_LEN_LO;
            end
          end
          LD_LEN_LO: begin
            if (w_xfer) begin
              r_len <= w_len[CntW-1:0];
              if (w_oversize) begin
                r_state <= LD_ERROR;
                r_ready <= 1'b0;
                r_error <= 1'b1;
              end else if (w_len == 16'd0) begin
                r_state <= LD_CHECK;
              end else begin
                r_state <= LD_PAYLOAD;
              end
            end
          end
          LD_PAYLOAD: begin
            if (w_xfer) begin
              r_xor <= r_xor ^ io_ld.s_data;
              if (w_word_done) begin
                r_we       <= 1'b1;
                r_wdata    <= w_word;
                r_word_cnt <= w_word_cnt_inc;
                if (w_word_cnt_inc == r_len) begin
                  r_state <= LD_CHECK;
                end
              end
            end
          end
          LD_CHECK: begin
            if (w_xfer) begin
              r_ready <= 1'b0;
              if (io_ld.s_data == r_xor) begin
                r_state <= LD_DONE;
                r_done  <= 1'b1;
                r_hold  <= 1'b0;
              end else begin
                r_state <= LD_ERROR;
                r_error <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io_ld.s_ready    = r_ready;
  assign io_ld.imem_we    = r_we;
  assign io_ld.imem_addr  = r_addr;
  assign io_ld.imem_wdata = r_wdata;
  assign io_ld.cpu_hold   = r_hold;
  assign io_ld.done       = r_done;
  assign io_ld.error      = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal, empty, bad-checksum, oversize, gapped and reset loads.
module tb_program_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  program_loader_if bus ();

  program_loader dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_ld   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int nwr     = 0;
  int cyc     = 0;
  int base;
  logic [7:0]  wa [16];
  logic [48:0] wd [16];
  int          wc [16];
  logic [7:0]  img [14];

  always @(negedge clk) begin
    cyc++;
    if (bus.imem_we) begin
      if (nwr < 16) begin
        wa[nwr] = bus.imem_addr;
        wd[nwr] = bus.imem_wdata;
        wc[nwr] = cyc;
      end
      nwr++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int waited;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    waited = 0;
    while (!bus.s_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited == 20) check("ready_timeout", 64'(bus.s_ready), 64'd1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("ready_after_start", 64'(bus.s_ready), 64'd1);
  endtask

  task automatic send_image(input bit gap, input logic [7:0] cks);
    send(8'h00, gap);
    send(8'h02, gap);
    for (int i = 0; i < 14; i++) send(img[i], gap);
    send(cks, gap);
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_nwr"},   64'(nwr - base), 64'd2);
    check({tag, "_addr0"}, 64'(wa[base]), 64'd0);
    check({tag, "_data0"}, 64'(wd[base]), 64'h1_0000_0000_002A);
    check({tag, "_addr1"}, 64'(wa[base+1]), 64'd1);
    check({tag, "_data1"}, 64'(wd[base+1]), 64'h0_FFFF_FFFF_FFFF);
  endtask

  initial begin
    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2A,
            8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    #12;
    check("rst_ready", 64'(bus.s_ready), 64'd0);
    check("rst_we",    64'(bus.imem_we), 64'd0);
    check("rst_addr",  64'(bus.imem_addr), 64'd0);
    check("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    check("rst_hold",  64'(bus.cpu_hold), 64'd1);
    check("rst_done",  64'(bus.done), 64'd0);
    check("rst_error", 64'(bus.error), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word load, no gaps
    base = nwr;
    pulse_start();
    send_image(1'b0, 8'h2B);
    check("ok_done",  64'(bus.done), 64'd1);
    check("ok_hold",  64'(bus.cpu_hold), 64'd0);
    check("ok_error", 64'(bus.error), 64'd0);
    check("ok_ready", 64'(bus.s_ready), 64'd0);
    check_two_writes("ok");
    check("ok_spacing", 64'(wc[base+1] - wc[base]), 64'd7);

    // Zero-length image
    base = nwr;
    pulse_start();
    check("zero_done_cleared", 64'(bus.done), 64'd0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check("zero_done", 64'(bus.done), 64'd1);
    check("zero_nwr",  64'(nwr - base), 64'd0);

    // Bad checksum
    base = nwr;
    pulse_start();
    send_image(1'b0, 8'h2C);
    check("bad_error", 64'(bus.error), 64'd1);
    check("bad_hold",  64'(bus.cpu_hold), 64'd1);
    check("bad_done",  64'(bus.done), 64'd0);
    check_two_writes("bad");

    // Oversize length 257
    base = nwr;
    pulse_start();
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    check("big_error", 64'(bus.error), 64'd1);
    check("big_ready", 64'(bus.s_ready), 64'd0);
    check("big_hold",  64'(bus.cpu_hold), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("big_nwr",   64'(nwr - base), 64'd0);

    // Backpressure gaps
    base = nwr;
    pulse_start();
    send_image(1'b1, 8'h2B);
    check("gap_done", 64'(bus.done), 64'd1);
    check("gap_hold", 64'(bus.cpu_hold), 64'd0);
    check_two_writes("gap");

    // Reset after the third payload byte, then a full reload
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    for (int i = 0; i < 3; i++) send(img[i], 1'b0);
    base = nwr;
    bus.s_data  = img[3];
    bus.s_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_ready", 64'(bus.s_ready), 64'd0);
    check("mid_we",    64'(bus.imem_we), 64'd0);
    check("mid_addr",  64'(bus.imem_addr), 64'd0);
    check("mid_wdata", 64'(bus.imem_wdata), 64'd0);
    check("mid_hold",  64'(bus.cpu_hold), 64'd1);
    check("mid_done",  64'(bus.done), 64'd0);
    bus.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("mid_nwr", 64'(nwr - base), 64'd0);
    check("mid_idle_ready", 64'(bus.s_ready), 64'd0);
    pulse_start();
    send_image(1'b0, 8'h2B);
    check("reload_done", 64'(bus.done), 64'd1);
    check_two_writes("reload");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
